// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM timing guard.
// Holds the command encoding, the per-bank state encoding and the
// default JEDEC timing values (in clock cycles, CAS-2 part).
package sdram_pkg;

   localparam int unsigned CMD_W = 4;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOOP           = 4'd0,
      CMD_ACTIVATE       = 4'd1,
      CMD_READ           = 4'd2,
      CMD_READA          = 4'd3,
      CMD_WRITE          = 4'd4,
      CMD_WRITEA         = 4'd5,
      CMD_PRECHARGE_BANK = 4'd6,
      CMD_PRECHARGE_ALL  = 4'd7,
      CMD_AREFRESH       = 4'd8,
      CMD_SET_MODE_REG   = 4'd9
   } cmd_e;

   typedef enum logic {
      BANK_IDLE   = 1'b0,
      BANK_ACTIVE = 1'b1
   } bank_state_e;

   localparam int unsigned DEF_NUM_BANKS = 4;
   localparam int unsigned DEF_CNT_W     = 4;
   localparam int unsigned DEF_T_RC      = 8;
   localparam int unsigned DEF_T_RCD     = 2;
   localparam int unsigned DEF_T_MRD     = 2;
   localparam int unsigned DEF_T_RP      = 2;
   localparam int unsigned DEF_T_DPL     = 2;
   localparam int unsigned DEF_T_RAS     = 5;
   localparam int unsigned DEF_T_DAL     = 4;
   localparam int unsigned DEF_T_REFI    = 780;
   localparam int unsigned DEF_REFI_W    = 10;

endpackage

// File: rtl/sdram_bank_timer.sv
// One bank's open/idle state plus its rcd/ras/rp/dpl/rc down-counters.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   act_go .. pre_go    issued command aimed at this bank (one-hot per cycle)
//   is_open_c           bank has an open row
//   act_ok_c            ACTIVATE timing met
//   rw_ok_c             READ/WRITE timing met
//   rwa_ok_c            READA/WRITEA timing met
//   pre_ok_c            PRECHARGE legal (idle, or ras and dpl expired)
//   rp_zero_c           precharge/auto-precharge recovery finished
// All *_c outputs are decodes of this block's own flops.
module sdram_bank_timer
   import sdram_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned T_RC  = DEF_T_RC,
   parameter int unsigned T_RCD = DEF_T_RCD,
   parameter int unsigned T_RP  = DEF_T_RP,
   parameter int unsigned T_DPL = DEF_T_DPL,
   parameter int unsigned T_RAS = DEF_T_RAS,
   parameter int unsigned T_DAL = DEF_T_DAL
) (
   input  logic clk,
   input  logic reset_n,
   input  logic act_go,
   input  logic wr_go,
   input  logic rda_go,
   input  logic wra_go,
   input  logic pre_go,
   output logic is_open_c,
   output logic act_ok_c,
   output logic rw_ok_c,
   output logic rwa_ok_c,
   output logic pre_ok_c,
   output logic rp_zero_c
);

   // A counter loaded with T-1 reaches zero exactly T cycles after the issue.
   localparam logic [CNT_W-1:0] RC_LD  = CNT_W'(T_RC  > 0 ? T_RC  - 1 : 0);
   localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD > 0 ? T_RCD - 1 : 0);
   localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP  > 0 ? T_RP  - 1 : 0);
   localparam logic [CNT_W-1:0] DPL_LD = CNT_W'(T_DPL > 0 ? T_DPL - 1 : 0);
   localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS > 0 ? T_RAS - 1 : 0);
   localparam logic [CNT_W-1:0] DAL_LD = CNT_W'(T_DAL > 0 ? T_DAL - 1 : 0);

   function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   bank_state_e      state_q, state_d;
   logic [CNT_W-1:0] rcd_q, ras_q, rp_q, dpl_q, rc_q;
   logic             pre_eff;

   // PRECHARGE to an idle bank is a no-op and must not restart tRP.
   assign pre_eff = pre_go & (state_q == BANK_ACTIVE);

   // Bank state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= BANK_IDLE;
      else          state_q <= state_d;
   end

   // Bank next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         BANK_IDLE:   if (act_go) state_d = BANK_ACTIVE;
         BANK_ACTIVE: if (rda_go || wra_go || pre_eff) state_d = BANK_IDLE;
      endcase
   end

   // Timing counters: load on issue, otherwise count down to zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rcd_q <= '0;
         ras_q <= '0;
         rp_q  <= '0;
         dpl_q <= '0;
         rc_q  <= '0;
      end else begin
         rcd_q <= act_go ? RCD_LD : dec(rcd_q);
         ras_q <= act_go ? RAS_LD : dec(ras_q);
         rc_q  <= act_go ? RC_LD  : dec(rc_q);
         dpl_q <= wr_go  ? DPL_LD : dec(dpl_q);
         if (wra_go)                rp_q <= DAL_LD;
         else if (rda_go || pre_eff) rp_q <= RP_LD;
         else                       rp_q <= dec(rp_q);
      end
   end

   assign is_open_c = (state_q == BANK_ACTIVE);
   assign rp_zero_c = (rp_q == '0);
   assign act_ok_c  = !is_open_c && rp_zero_c && (rc_q == '0);
   assign rw_ok_c   = is_open_c && (rcd_q == '0);
   assign rwa_ok_c  = rw_ok_c && (ras_q == '0);
   assign pre_ok_c  = !is_open_c || ((ras_q == '0) && (dpl_q == '0));

endmodule

// File: rtl/sdram_timing_guard.sv
// Per-bank SDRAM command legality checker and refresh scheduler, placed
// between the controller FSM and the pin driver.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   cmd_valid      controller proposes cmd this cycle
//   cmd            command code (sdram_pkg::cmd_e)
//   cmd_bank       target bank
//   cmd_ready      combinational: proposed command is legal now
//   bank_open      per-bank open-row flags
//   refresh_due    refresh interval expired (held until AREFRESH issues)
//   all_idle       every bank idle and recovered from precharge
// Optional (macro SDRAM_GUARD_ERR_EN):
//   err, err_cmd   sticky flag and code of the first held-off command
module sdram_timing_guard
   import sdram_pkg::*;
#(
   parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned T_RC      = DEF_T_RC,
   parameter int unsigned T_RCD     = DEF_T_RCD,
   parameter int unsigned T_MRD     = DEF_T_MRD,
   parameter int unsigned T_RP      = DEF_T_RP,
   parameter int unsigned T_DPL     = DEF_T_DPL,
   parameter int unsigned T_RAS     = DEF_T_RAS,
   parameter int unsigned T_DAL     = DEF_T_DAL,
   parameter int unsigned T_REFI    = DEF_T_REFI,
   parameter int unsigned REFI_W    = DEF_REFI_W,
   localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   input  logic [CMD_W-1:0]     cmd,
   input  logic [BANK_W-1:0]    cmd_bank,
   output logic                 cmd_ready,
   output logic [NUM_BANKS-1:0] bank_open,
   output logic                 refresh_due,
   output logic                 all_idle
`ifdef SDRAM_GUARD_ERR_EN
   ,
   output logic                 err,
   output logic [CMD_W-1:0]     err_cmd
`endif
);

   // Per-bank vectors are padded to the full cmd_bank range so any index is legal.
   localparam int unsigned NB_PAD = 1 << BANK_W;

   localparam logic [CNT_W-1:0]  MRD_LD = CNT_W'(T_MRD > 0 ? T_MRD - 1 : 0);
   localparam logic [CNT_W-1:0]  REF_LD = CNT_W'(T_RC  > 0 ? T_RC  - 1 : 0);
   localparam logic [REFI_W-1:0] DUE_AT = REFI_W'(T_REFI > 0 ? T_REFI - 1 : 0);

   function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   logic [NB_PAD-1:0] act_ok, rw_ok, rwa_ok, pre_ok, rp_zero, open_v;
   logic [CNT_W-1:0]  mrd_q, ref_q;
   logic [REFI_W-1:0] refi_q;
   logic              issue, bank_ok, gate_ok, prea_ok;

   assign issue   = cmd_valid & cmd_ready;
   assign bank_ok = (32'(cmd_bank) < NUM_BANKS);
   assign gate_ok = bank_ok && (mrd_q == '0);

   // Bank timers; padding slots read as closed, not ready, recovered
   for (genvar b = 0; b < NB_PAD; b++) begin : g_bank
      if (b < NUM_BANKS) begin : g_live
         logic sel;
         assign sel = issue && (cmd_bank == BANK_W'(b));
         sdram_bank_timer #(
            .CNT_W (CNT_W),
            .T_RC  (T_RC),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_DPL (T_DPL),
            .T_RAS (T_RAS),
            .T_DAL (T_DAL)
         ) u_timer (
            .clk       (clk),
            .reset_n   (reset_n),
            .act_go    (sel && (cmd == CMD_ACTIVATE)),
            .wr_go     (sel && (cmd == CMD_WRITE)),
            .rda_go    (sel && (cmd == CMD_READA)),
            .wra_go    (sel && (cmd == CMD_WRITEA)),
            .pre_go    ((sel && (cmd == CMD_PRECHARGE_BANK)) ||
                        (issue && (cmd == CMD_PRECHARGE_ALL))),
            .is_open_c (open_v[b]),
            .act_ok_c  (act_ok[b]),
            .rw_ok_c   (rw_ok[b]),
            .rwa_ok_c  (rwa_ok[b]),
            .pre_ok_c  (pre_ok[b]),
            .rp_zero_c (rp_zero[b])
         );
      end else begin : g_pad
         assign open_v[b]  = 1'b0;
         assign act_ok[b]  = 1'b0;
         assign rw_ok[b]   = 1'b0;
         assign rwa_ok[b]  = 1'b0;
         assign pre_ok[b]  = 1'b0;
         assign rp_zero[b] = 1'b1;
      end
   end

   assign bank_open = open_v[NUM_BANKS-1:0];
   assign all_idle  = !(|open_v[NUM_BANKS-1:0]) && (&rp_zero[NUM_BANKS-1:0]);
   // Idle banks report pre_ok=1, so the AND covers only the active ones.
   assign prea_ok   = &pre_ok[NUM_BANKS-1:0];

   // Command legality decode
   always_comb begin
      cmd_ready = 1'b0;
      case (cmd)
         CMD_NOOP:                      cmd_ready = 1'b1;
         CMD_ACTIVATE:                  cmd_ready = gate_ok && act_ok[cmd_bank] && (ref_q == '0);
         CMD_READ, CMD_WRITE:           cmd_ready = gate_ok && rw_ok[cmd_bank];
         CMD_READA, CMD_WRITEA:         cmd_ready = gate_ok && rwa_ok[cmd_bank];
         CMD_PRECHARGE_BANK:            cmd_ready = gate_ok && pre_ok[cmd_bank];
         CMD_PRECHARGE_ALL:             cmd_ready = gate_ok && prea_ok;
         CMD_AREFRESH, CMD_SET_MODE_REG: cmd_ready = gate_ok && all_idle && (ref_q == '0);
         default:                       cmd_ready = 1'b0;
      endcase
   end

   // Global mode-register, refresh-cycle and refresh-interval counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mrd_q  <= '0;
         ref_q  <= '0;
         refi_q <= '0;
      end else begin
         mrd_q <= (issue && (cmd == CMD_SET_MODE_REG)) ? MRD_LD : dec(mrd_q);
         if (issue && (cmd == CMD_AREFRESH)) begin
            ref_q  <= REF_LD;
            refi_q <= '0;
         end else begin
            ref_q  <= dec(ref_q);
            refi_q <= (&refi_q) ? refi_q : refi_q + REFI_W'(1);
         end
      end
   end

   assign refresh_due = (refi_q >= DUE_AT);

`ifdef SDRAM_GUARD_ERR_EN
   // Sticky capture of the first non-NOOP command that was held off
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err     <= 1'b0;
         err_cmd <= '0;
      end else if (!err && cmd_valid && !cmd_ready && (cmd != CMD_NOOP)) begin
         err     <= 1'b1;
         err_cmd <= cmd;
      end
   end
`endif

endmodule
